// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file write-back path.
//   XLEN        width of write-back data
//   NREG        number of architectural registers (x0 reads as zero)
//   AW          register address width
//   reg_addr_t  register index type
//   wb_src_e    identifies which producer owns the write port
package regfile_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef logic [AW-1:0] reg_addr_t;

  typedef enum logic {
    GNT_EX  = 1'b0,
    GNT_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Write-back bus: the two result streams (ALU and load) with valid/ready
// handshakes, plus the registered register-file write port.
//   master : producer/regfile side (drives results, observes ready and rf_*)
//   slave  : write-back controller side
interface regfile_wb_ctrl_if;
  import regfile_pkg::*;

  logic            ex_valid;
  reg_addr_t       ex_rd;
  logic [XLEN-1:0] ex_data;
  logic            ex_ready;

  logic            mem_valid;
  reg_addr_t       mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            mem_ready;

  logic            rf_we;
  reg_addr_t       rf_wa;
  logic [XLEN-1:0] rf_wd;

  modport master (
    output ex_valid, ex_rd, ex_data,
    input  ex_ready,
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    input  rf_we, rf_wa, rf_wd
  );

  modport slave (
    input  ex_valid, ex_rd, ex_data,
    output ex_ready,
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    output rf_we, rf_wa, rf_wd
  );

endinterface

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter for the register-file write port.
//   clk, reset          clock / synchronous active-high reset
//   ex_valid, mem_valid requests from the ALU and load streams
//   gnt_ex, gnt_mem     one-hot (or zero) grant, combinational from valids
// A lone request is always granted. On a tie the side not granted last wins;
// the history flop only moves when a grant actually happens.
module wb_rr_arbiter
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ex_valid,
  input  logic mem_valid,
  output logic gnt_ex,
  output logic gnt_mem
);

  wb_src_e last_grant_reg;

  always_comb begin
    gnt_ex  = ex_valid  && (!mem_valid || (last_grant_reg == GNT_MEM));
    gnt_mem = mem_valid && (!ex_valid  || (last_grant_reg == GNT_EX));
  end

  // Reset to MEM so the ALU wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= GNT_MEM;
    end else if (gnt_ex) begin
      last_grant_reg <= GNT_EX;
    end else if (gnt_mem) begin
      last_grant_reg <= GNT_MEM;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller for the 2R1W integer register file.
//   clk, reset      clock / synchronous active-high reset
//   bus             result streams in, registered rf write out
//   iss_*           decode's current instruction (sources, destination)
//   iss_stall       decode must hold (combinational)
//   pending         per-register write-in-flight scoreboard, bit 0 always 0
//   busy            any register pending
//   wb_err          sticky: a result arrived for a register not pending
module regfile_wb_ctrl
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  regfile_wb_ctrl_if.slave    bus,
  input  logic                iss_valid,
  input  reg_addr_t           iss_rs1,
  input  logic                iss_rs1_en,
  input  reg_addr_t           iss_rs2,
  input  logic                iss_rs2_en,
  input  reg_addr_t           iss_rd,
  input  logic                iss_rd_en,
  output logic                iss_stall,
  output logic [NREG-1:0]     pending,
  output logic                busy,
  output logic                wb_err
);

  logic            gnt_ex;
  logic            gnt_mem;
  logic            accept;
  reg_addr_t       acc_rd;
  logic [XLEN-1:0] acc_data;
  logic            acc_nonzero;
  logic            set_en;

  logic            rf_we_reg;
  reg_addr_t       rf_wa_reg;
  logic [XLEN-1:0] rf_wd_reg;
  logic [NREG-1:0] pending_reg;
  logic [NREG-1:0] pending_next;
  logic            wb_err_reg;

  wb_rr_arbiter u_arb (
    .clk       (clk),
    .reset     (reset),
    .ex_valid  (bus.ex_valid),
    .mem_valid (bus.mem_valid),
    .gnt_ex    (gnt_ex),
    .gnt_mem   (gnt_mem)
  );

  assign bus.ex_ready  = gnt_ex;
  assign bus.mem_ready = gnt_mem;

  assign accept      = gnt_ex || gnt_mem;
  assign acc_rd      = gnt_ex ? bus.ex_rd   : bus.mem_rd;
  assign acc_data    = gnt_ex ? bus.ex_data : bus.mem_data;
  assign acc_nonzero = (acc_rd != '0);

  // Hazard check sees only the current scoreboard: a write landing on this
  // edge has not reached the regfile yet, so its readers must still wait.
  assign iss_stall = iss_valid &&
                     ((iss_rs1_en && pending_reg[iss_rs1]) ||
                      (iss_rs2_en && pending_reg[iss_rs2]) ||
                      (iss_rd_en  && pending_reg[iss_rd]));

  assign set_en = iss_valid && !iss_stall && iss_rd_en && (iss_rd != '0);

  // Per-register next state; a new issue outranks a landing write-back.
  assign pending_next[0] = 1'b0;
  for (genvar gi = 1; gi < NREG; gi++) begin : g_pend
    assign pending_next[gi] =
      (set_en && (iss_rd == reg_addr_t'(gi))) ? 1'b1 :
      (rf_we_reg && (rf_wa_reg == reg_addr_t'(gi))) ? 1'b0 :
      pending_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_reg   <= 1'b0;
      rf_wa_reg   <= '0;
      rf_wd_reg   <= '0;
      pending_reg <= '0;
      wb_err_reg  <= 1'b0;
    end else begin
      // rd==0 results are accepted but never reach the regfile.
      rf_we_reg <= accept && acc_nonzero;
      if (accept) begin
        rf_wa_reg <= acc_rd;
        rf_wd_reg <= acc_data;
      end
      pending_reg <= pending_next;
      if (accept && acc_nonzero && !pending_reg[acc_rd]) begin
        wb_err_reg <= 1'b1;
      end
    end
  end

  assign bus.rf_we = rf_we_reg;
  assign bus.rf_wa = rf_wa_reg;
  assign bus.rf_wd = rf_wd_reg;
  assign pending   = pending_reg;
  assign busy      = |pending_reg;
  assign wb_err    = wb_err_reg;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;
  import regfile_pkg::*;

  logic            clk;
  logic            reset;
  logic            iss_valid;
  reg_addr_t       iss_rs1;
  logic            iss_rs1_en;
  reg_addr_t       iss_rs2;
  logic            iss_rs2_en;
  reg_addr_t       iss_rd;
  logic            iss_rd_en;
  logic            iss_stall;
  logic [NREG-1:0] pending;
  logic            busy;
  logic            wb_err;

  regfile_wb_ctrl_if bus ();

  regfile_wb_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .iss_valid  (iss_valid),
    .iss_rs1    (iss_rs1),
    .iss_rs1_en (iss_rs1_en),
    .iss_rs2    (iss_rs2),
    .iss_rs2_en (iss_rs2_en),
    .iss_rd     (iss_rd),
    .iss_rd_en  (iss_rd_en),
    .iss_stall  (iss_stall),
    .pending    (pending),
    .busy       (busy),
    .wb_err     (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [NREG-1:0]      m_pend;
  logic                 m_last;   // 0 = EX granted last, 1 = MEM
  logic                 m_we;
  reg_addr_t            m_wa;
  logic                 m_err;
  logic                 obs_ex_ready;
  logic                 obs_mem_ready;
  logic                 obs_stall;
  logic [AW+XLEN-1:0]   exp_q[$];

  task automatic idle_inputs();
    bus.ex_valid  = 1'b0;
    bus.ex_rd     = '0;
    bus.ex_data   = '0;
    bus.mem_valid = 1'b0;
    bus.mem_rd    = '0;
    bus.mem_data  = '0;
    iss_valid  = 1'b0;
    iss_rs1    = '0;
    iss_rs1_en = 1'b0;
    iss_rs2    = '0;
    iss_rs2_en = 1'b0;
    iss_rd     = '0;
    iss_rd_en  = 1'b0;
  endtask

  // One clock with inputs already driven: check combinational outputs and
  // scoreboard, push expected writes, advance model, check rf write port.
  task automatic cycle();
    logic            g_ex, g_mem, st, acc;
    reg_addr_t       a_rd;
    logic [XLEN-1:0] a_d;
    logic [NREG-1:0] p;
    logic            err_n;
    logic [AW+XLEN-1:0] e;
    #1;
    g_ex  = bus.ex_valid  && (!bus.mem_valid || m_last == 1'b1);
    g_mem = bus.mem_valid && (!bus.ex_valid  || m_last == 1'b0);
    st = iss_valid && ((iss_rs1_en && m_pend[iss_rs1]) ||
                       (iss_rs2_en && m_pend[iss_rs2]) ||
                       (iss_rd_en  && m_pend[iss_rd]));
    obs_ex_ready  = bus.ex_ready;
    obs_mem_ready = bus.mem_ready;
    obs_stall     = iss_stall;
    checks++;
    if (bus.ex_ready !== g_ex) begin
      errors++; $display("FAIL ex_ready: got %b expected %b", bus.ex_ready, g_ex);
    end
    checks++;
    if (bus.mem_ready !== g_mem) begin
      errors++; $display("FAIL mem_ready: got %b expected %b", bus.mem_ready, g_mem);
    end
    checks++;
    if (iss_stall !== st) begin
      errors++; $display("FAIL iss_stall: got %b expected %b", iss_stall, st);
    end
    checks++;
    if (pending !== m_pend || busy !== (|m_pend)) begin
      errors++; $display("FAIL pending: got %h/%b expected %h/%b", pending, busy, m_pend, |m_pend);
    end
    checks++;
    if (wb_err !== m_err) begin
      errors++; $display("FAIL wb_err: got %b expected %b", wb_err, m_err);
    end
    acc  = g_ex || g_mem;
    a_rd = g_ex ? bus.ex_rd   : bus.mem_rd;
    a_d  = g_ex ? bus.ex_data : bus.mem_data;
    err_n = m_err;
    if (acc && a_rd != '0) begin
      exp_q.push_back({a_rd, a_d});
      if (!m_pend[a_rd]) err_n = 1'b1;
    end
    p = m_pend;
    if (m_we) p[m_wa] = 1'b0;
    if (iss_valid && !st && iss_rd_en && iss_rd != '0) p[iss_rd] = 1'b1;
    p[0] = 1'b0;
    @(posedge clk);
    #1;
    m_pend = p;
    m_err  = err_n;
    m_we   = acc && (a_rd != '0);
    if (acc) m_wa = a_rd;
    if (g_ex) m_last = 1'b0;
    else if (g_mem) m_last = 1'b1;
    checks++;
    if (bus.rf_we !== m_we) begin
      errors++; $display("FAIL rf_we: got %b expected %b", bus.rf_we, m_we);
    end
    if (bus.rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL rf_write: got wa=%0d wd=%h expected no write", bus.rf_wa, bus.rf_wd);
      end else begin
        e = exp_q.pop_front();
        if ({bus.rf_wa, bus.rf_wd} !== e) begin
          errors++;
          $display("FAIL rf_write: got wa=%0d wd=%h expected wa=%0d wd=%h",
                   bus.rf_wa, bus.rf_wd, e[AW+XLEN-1:XLEN], e[XLEN-1:0]);
        end else begin
          $display("wb: wa=%0d wd=%h", bus.rf_wa, bus.rf_wd);
        end
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_pend = '0; m_last = 1'b1; m_we = 1'b0; m_wa = '0; m_err = 1'b0;
    exp_q.delete();
    checks++;
    if (bus.rf_we !== 1'b0 || bus.rf_wa !== '0 || bus.rf_wd !== '0) begin
      errors++; $display("FAIL reset_rf: got we=%b wa=%0d wd=%h expected 0/0/0", bus.rf_we, bus.rf_wa, bus.rf_wd);
    end
    checks++;
    if (pending !== '0 || busy !== 1'b0 || wb_err !== 1'b0) begin
      errors++; $display("FAIL reset_sb: got pending=%h busy=%b wb_err=%b expected 0/0/0", pending, busy, wb_err);
    end
    $display("reset applied");
  endtask

  task automatic test_single_ex();
    test_reset();
    bus.ex_valid = 1'b1; bus.ex_rd = 5'd5; bus.ex_data = 32'hDEADBEEF;
    cycle();
    checks++;
    if (obs_ex_ready !== 1'b1) begin
      errors++; $display("FAIL single_ex_ready: got %b expected 1", obs_ex_ready);
    end
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_wa !== 5'd5 || bus.rf_wd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_ex_write: got %b/%0d/%h expected 1/5/deadbeef", bus.rf_we, bus.rf_wa, bus.rf_wd);
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_round_robin();
    logic exp_ex[3];
    exp_ex[0] = 1'b1; exp_ex[1] = 1'b0; exp_ex[2] = 1'b1;
    test_reset();
    bus.ex_valid  = 1'b1; bus.ex_rd  = 5'd3; bus.ex_data  = 32'h0000_0300;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'h0000_0700;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (obs_ex_ready !== exp_ex[i] || obs_mem_ready !== !exp_ex[i]) begin
        errors++; $display("FAIL rr_grant%0d: got ex=%b mem=%b expected ex=%b", i, obs_ex_ready, obs_mem_ready, exp_ex[i]);
      end
      // A granted producer moves on to a fresh result; the loser holds.
      if (obs_ex_ready)  bus.ex_data  = bus.ex_data + 32'd1;
      if (obs_mem_ready) bus.mem_data = bus.mem_data + 32'd1;
    end
    idle_inputs();
    cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rr_lost: got %0d writes outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic test_raw_stall();
    test_reset();
    iss_valid = 1'b1; iss_rd = 5'd9; iss_rd_en = 1'b1;
    cycle();
    iss_rd_en = 1'b0; iss_rs1 = 5'd9; iss_rs1_en = 1'b1;
    cycle();
    checks++;
    if (obs_stall !== 1'b1) begin
      errors++; $display("FAIL raw_stall_held: got %b expected 1", obs_stall);
    end
    bus.ex_valid = 1'b1; bus.ex_rd = 5'd9; bus.ex_data = 32'h1234_5678;
    cycle();
    bus.ex_valid = 1'b0;
    cycle();          // write lands on this edge; still stalled before it
    checks++;
    if (obs_stall !== 1'b1) begin
      errors++; $display("FAIL raw_stall_landing: got %b expected 1", obs_stall);
    end
    cycle();
    checks++;
    if (obs_stall !== 1'b0) begin
      errors++; $display("FAIL raw_stall_release: got %b expected 0", obs_stall);
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_set_clear_same_edge();
    test_reset();
    bus.ex_valid = 1'b1; bus.ex_rd = 5'd9; bus.ex_data = 32'hAAAA_0009;
    cycle();
    bus.ex_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd9; iss_rd_en = 1'b1;
    cycle();          // rf write to 9 and new issue rd=9 on the same edge
    idle_inputs();
    checks++;
    if (pending[9] !== 1'b1) begin
      errors++; $display("FAIL set_wins: got pending[9]=%b expected 1", pending[9]);
    end
    cycle();
  endtask

  task automatic test_rd_zero_and_err();
    test_reset();
    bus.ex_valid = 1'b1; bus.ex_rd = 5'd0; bus.ex_data = 32'hFFFF_FFFF;
    cycle();
    bus.ex_valid = 1'b0;
    checks++;
    if (obs_ex_ready !== 1'b1 || bus.rf_we !== 1'b0 || wb_err !== 1'b0) begin
      errors++; $display("FAIL rd_zero: got ready=%b we=%b err=%b expected 1/0/0", obs_ex_ready, bus.rf_we, wb_err);
    end
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 32'h0000_0444;
    cycle();
    bus.mem_valid = 1'b0;
    checks++;
    if (wb_err !== 1'b1) begin
      errors++; $display("FAIL wb_err_set: got %b expected 1", wb_err);
    end
    for (int i = 0; i < 3; i++) cycle();
    checks++;
    if (wb_err !== 1'b1) begin
      errors++; $display("FAIL wb_err_sticky: got %b expected 1", wb_err);
    end
  endtask

  task automatic test_reset_mid();
    test_reset();
    iss_valid = 1'b1; iss_rd = 5'd2; iss_rd_en = 1'b1;
    cycle();
    iss_rd = 5'd6;
    cycle();
    idle_inputs();
    bus.ex_valid = 1'b1; bus.ex_rd = 5'd2; bus.ex_data = 32'h2222_2222;
    cycle();
    bus.ex_valid = 1'b0;
    checks++;
    if (pending[2] !== 1'b1 || pending[6] !== 1'b1 || bus.rf_we !== 1'b1) begin
      errors++; $display("FAIL mid_setup: got pending=%h we=%b expected bits 2,6 and we=1", pending, bus.rf_we);
    end
    test_reset();
    cycle();
  endtask

  task automatic test_back_to_back();
    test_reset();
    for (int i = 0; i < 300; i++) begin
      if (!bus.ex_valid || obs_ex_ready) begin
        bus.ex_valid = 1'($urandom_range(0, 1));
        bus.ex_rd    = reg_addr_t'($urandom_range(0, 7));
        bus.ex_data  = $urandom;
      end
      if (!bus.mem_valid || obs_mem_ready) begin
        bus.mem_valid = 1'($urandom_range(0, 1));
        bus.mem_rd    = reg_addr_t'($urandom_range(0, 7));
        bus.mem_data  = $urandom;
      end
      iss_valid  = 1'($urandom_range(0, 1));
      iss_rs1    = reg_addr_t'($urandom_range(0, 7));
      iss_rs1_en = 1'($urandom_range(0, 1));
      iss_rs2    = reg_addr_t'($urandom_range(0, 7));
      iss_rs2_en = 1'($urandom_range(0, 1));
      iss_rd     = reg_addr_t'($urandom_range(0, 7));
      iss_rd_en  = 1'($urandom_range(0, 1));
      cycle();
    end
    idle_inputs();
    cycle();
    cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_lost: got %0d writes outstanding expected 0", exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    obs_ex_ready = 1'b0; obs_mem_ready = 1'b0; obs_stall = 1'b0;
    test_reset();
    test_single_ex();
    test_round_robin();
    test_raw_stall();
    test_set_clear_same_edge();
    test_rd_zero_and_err();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
